// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Streams one frame out of a frame buffer in raster order. Geometry is picked
//   by IMAGE_STATE when a frame starts (2 -> 80x60, 1 -> 320x240,
//   0/3 -> 160x120). Reads have a fixed one-cycle latency. Returned data lands
//   in a two-entry output buffer that is drained over a valid/ready handshake.
//
//   Optional feature: define FB_READER_CHECKSUM_EN to add the CHECKSUM output.
//   CHECKSUM is the modulo-2^16 sum of the pixels accepted in the current frame.
//
// Ports
//   CLK          in   clock; all state changes on the rising edge
//   RESET        in   synchronous, active-high reset
//   start        in   level request to stream one frame
//   IMAGE_STATE  in   [1:0] geometry select, sampled on IDLE->RUN
//   RD_ADDR      out  [ADDR_W-1:0] frame-buffer read address (0 when rden low)
//   rden         out  frame-buffer read strobe
//   RD_DATA      in   [DATA_W-1:0] read data, valid one cycle after rden
//   PIXEL_OUT    out  [DATA_W-1:0] streamed pixel
//   pixel_valid  out  PIXEL_OUT/X_OUT/Y_OUT/last are valid
//   pixel_ready  in   downstream accept
//   X_OUT        out  [8:0] column of PIXEL_OUT
//   Y_OUT        out  [7:0] row of PIXEL_OUT
//   last         out  final pixel of the frame
//   busy         out  high in RUN and DRAIN
//   done         out  high in DONE
//   CHECKSUM     out  [15:0] (FB_READER_CHECKSUM_EN only)
//
// state  | meaning
// IDLE   | waiting for start; geometry latched on exit
// RUN    | issuing reads 0 .. W*H-1, throttled by output buffer space
// DRAIN  | all reads issued; emptying the output buffer
// DONE   | frame complete; waits for start to drop
module framebuffer_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [1:0]        IMAGE_STATE,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              rden,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] PIXEL_OUT,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic [8:0]        X_OUT,
  output logic [7:0]        Y_OUT,
  output logic              last,
  output logic              busy,
  output logic              done
`ifdef FB_READER_CHECKSUM_EN
  ,
  output logic [15:0]       CHECKSUM
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  // Latched frame geometry
  logic [8:0]        geo_w;
  logic [7:0]        geo_h;
  logic [ADDR_W-1:0] geo_total;
  logic [8:0]        sel_w;
  logic [7:0]        sel_h;
  logic [ADDR_W-1:0] sel_total;

  // Read side
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;

  // Two-entry output buffer
  logic [DATA_W-1:0] buf0, buf1;
  logic              wr_sel, rd_sel;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] head_data;

  // Coordinates of the buffer head
  logic [8:0]        x_cnt;
  logic [7:0]        y_cnt;

  logic              push, pop;
  logic              start_frame;
  logic              last_read;
  logic              head_last;
  logic [2:0]        occ_after;

  always_comb begin
    sel_w     = 9'd160;
    sel_h     = 8'd120;
    sel_total = ADDR_W'(19200);
    case (IMAGE_STATE)
      2'd2: begin
        sel_w     = 9'd80;
        sel_h     = 8'd60;
        sel_total = ADDR_W'(4800);
      end
      2'd1: begin
        sel_w     = 9'd320;
        sel_h     = 8'd240;
        sel_total = ADDR_W'(76800);
      end
      default: ;
    endcase
  end

  assign pixel_valid = (buf_cnt != 2'd0);
  assign pop         = pixel_valid & pixel_ready;
  assign push        = inflight;
  assign head_data   = rd_sel ? buf1 : buf0;
  assign head_last   = (x_cnt == geo_w - 9'd1) && (y_cnt == geo_h - 8'd1);

  // Occupancy once this cycle's pop has happened. Counting the pop lets a read
  // go out every cycle while the consumer keeps up, and the buffer still
  // cannot overflow because the returning data only lands after the pop.
  assign occ_after = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nx    = state;
    rden        = 1'b0;
    start_frame = 1'b0;
    last_read   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_nx    = S_RUN;
        end
      end
      S_RUN: begin
        rden      = (occ_after < 3'd2);
        last_read = rden && (rd_ptr == geo_total - ADDR_W'(1));
        if (last_read) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      geo_w     <= '0;
      geo_h     <= '0;
      geo_total <= '0;
    end else if (start_frame) begin
      geo_w     <= sel_w;
      geo_h     <= sel_h;
      geo_total <= sel_total;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rden;
      if (start_frame) begin
        rd_ptr <= '0;
      end else if (rden) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf0    <= '0;
      buf1    <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) begin
        if (wr_sel) begin
          buf1 <= RD_DATA;
        end else begin
          buf0 <= RD_DATA;
        end
        wr_sel <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (start_frame) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pop) begin
      if (x_cnt == geo_w - 9'd1) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == geo_h - 8'd1) ? 8'd0 : y_cnt + 8'd1;
      end else begin
        x_cnt <= x_cnt + 9'd1;
      end
    end
  end

  // Handshake-side outputs read as zero whenever nothing is offered.
  assign RD_ADDR   = rden ? rd_ptr : '0;
  assign PIXEL_OUT = pixel_valid ? head_data : '0;
  assign X_OUT     = pixel_valid ? x_cnt : 9'd0;
  assign Y_OUT     = pixel_valid ? y_cnt : 8'd0;
  assign last      = pixel_valid & head_last;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

`ifdef FB_READER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CHECKSUM <= '0;
    end else if (start_frame) begin
      CHECKSUM <= '0;
    end else if (pop) begin
      CHECKSUM <= CHECKSUM + 16'(head_data);
    end
  end
`else
  // Checksum datapath is not built in this configuration.
`endif

endmodule
